eth_rx_mii: RTL and testbench

MII receive front end for the Ethernet MAC, the receive-direction counterpart of the MII transmit path. It samples 4-bit MII receive nibbles on `MRxClk` and strips preamble and SFD. It assembles the frame bytes into 32-bit little-endian words, checks the CRC-32 FCS, and reports per-frame status. Its output is a non-stallable word stream that feeds the receive buffer / DMA writer toward the APB memory master port.

---
 rtl/eth_rx_mii.sv | 230 +++++++++++++++++++++++
 tb/tb_eth_rx_mii.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_mii.sv
// -----------------------------------------------------------------------------
// eth_rx_mii
//
// MII receive front end. Nibbles sampled on MRxClk are stripped of preamble
// and SFD, then packed into 32-bit little-endian words that stream out without
// backpressure. The FCS is checked with a CRC-32 residue test, and per-frame
// status is reported with a one-cycle rx_done_o pulse.
//
// Parameters:
//   MIN_LEN  minimum legal frame length in bytes (FCS included)
//   MAX_LEN  maximum legal frame length in bytes (FCS included)
//
// Ports:
//   MRxClk          receive clock, all logic on its rising edge
//   prstn_i         asynchronous active-low reset
//   MRxD/MRxDV/MRxErr  MII receive nibble, data valid, PHY error
//   rx_data_o       assembled word, byte 0 in [7:0]
//   rx_valid_o      one-cycle strobe for rx_data_o / rx_be_o / rx_sof_o
//   rx_be_o         byte enables (1111, or 0001/0011/0111 on the last word)
//   rx_sof_o        first word of a frame
//   rx_done_o       one-cycle end-of-frame strobe, status valid
//   rx_len_o        frame byte count including FCS (saturating)
//   rx_crc_err_o, rx_phy_err_o, rx_short_err_o, rx_long_err_o, rx_align_err_o
//                   per-frame status, held until the next rx_done_o
// -----------------------------------------------------------------------------
module eth_rx_mii #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        MRxClk,
  input  logic        prstn_i,
  input  logic [3:0]  MRxD,
  input  logic        MRxDV,
  input  logic        MRxErr,
  output logic [31:0] rx_data_o,
  output logic        rx_valid_o,
  output logic [3:0]  rx_be_o,
  output logic        rx_sof_o,
  output logic        rx_done_o,
  output logic [15:0] rx_len_o,
  output logic        rx_crc_err_o,
  output logic        rx_phy_err_o,
  output logic        rx_short_err_o,
  output logic        rx_long_err_o,
  output logic        rx_align_err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DROP
  } state_e;

  // Register orientation is MSB-first with data bits fed LSB-first, so the
  // good-frame residue appears bit-reversed relative to the reflected form.
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [15:0] MIN_LEN_W   = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN_W   = 16'(MAX_LEN);

  function automatic logic [31:0] crc_fold(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] r;
    r = crc;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ data[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
      else                 r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  state_e      state_q;
  logic        dv_prev_q;
  logic        armed_q;       // set once DV has been seen low after reset
  logic        phase_q;       // 1: low nibble held, waiting for high nibble
  logic        from_data_q;   // DROP was entered from DATA (oversize)
  logic        first_word_q;
  logic        phy_err_q;
  logic        long_err_q;
  logic [3:0]  low_nib_q;
  logic [15:0] count_q;
  logic [31:0] crc_q;
  logic [31:0] word_q;

  logic [7:0]  byte_w;
  logic [1:0]  lane_w;
  logic [31:0] crc_byte_w;
  logic [15:0] count_inc_w;
  logic [31:0] word_ins_w;
  logic [3:0]  tail_be_w;
  logic        end_frame_w;
  logic        align_w;

  always_comb begin
    byte_w      = {MRxD, low_nib_q};
    lane_w      = count_q[1:0];
    crc_byte_w  = crc_fold(crc_q, byte_w);
    count_inc_w = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    word_ins_w  = word_q;
    word_ins_w[{lane_w, 3'b000} +: 8] = byte_w;
    case (lane_w)
      2'd1:    tail_be_w = 4'b0001;
      2'd2:    tail_be_w = 4'b0011;
      2'd3:    tail_be_w = 4'b0111;
      default: tail_be_w = 4'b0000;
    endcase
    // Frame-ending DV fall: from DATA, or from DROP after an oversize cut.
    end_frame_w = !MRxDV && ((state_q == S_DATA) || (state_q == S_DROP && from_data_q));
    // Only a DATA-state end can leave a dangling low nibble.
    align_w     = (state_q == S_DATA) && phase_q;
  end

  always_ff @(posedge MRxClk or negedge prstn_i) begin
    if (!prstn_i) begin
      state_q        <= S_IDLE;
      dv_prev_q      <= 1'b0;
      armed_q        <= 1'b0;
      phase_q        <= 1'b0;
      from_data_q    <= 1'b0;
      first_word_q   <= 1'b0;
      phy_err_q      <= 1'b0;
      long_err_q     <= 1'b0;
      low_nib_q      <= 4'h0;
      count_q        <= 16'h0;
      crc_q          <= 32'h0;
      word_q         <= 32'h0;
      rx_data_o      <= 32'h0;
      rx_valid_o     <= 1'b0;
      rx_be_o        <= 4'h0;
      rx_sof_o       <= 1'b0;
      rx_done_o      <= 1'b0;
      rx_len_o       <= 16'h0;
      rx_crc_err_o   <= 1'b0;
      rx_phy_err_o   <= 1'b0;
      rx_short_err_o <= 1'b0;
      rx_long_err_o  <= 1'b0;
      rx_align_err_o <= 1'b0;
    end else begin
      dv_prev_q  <= MRxDV;
      if (!MRxDV) armed_q <= 1'b1;
      rx_valid_o <= 1'b0;
      rx_sof_o   <= 1'b0;
      rx_done_o  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // armed_q keeps a DV that stayed high across reset from
          // looking like a fresh 0->1 edge.
          if (armed_q && MRxDV && !dv_prev_q) begin
            state_q     <= (MRxD == 4'h5) ? S_PREAMBLE : S_DROP;
            from_data_q <= 1'b0;
          end
        end

        S_PREAMBLE: begin
          if (!MRxDV) begin
            state_q <= S_IDLE;
          end else if (MRxD == 4'hD) begin
            state_q      <= S_DATA;
            phase_q      <= 1'b0;
            count_q      <= 16'h0;
            crc_q        <= 32'hFFFFFFFF;
            word_q       <= 32'h0;
            first_word_q <= 1'b1;
            phy_err_q    <= 1'b0;
            long_err_q   <= 1'b0;
          end else if (MRxD != 4'h5) begin
            state_q     <= S_DROP;
            from_data_q <= 1'b0;
          end
        end

        S_DATA: begin
          if (!MRxDV) begin
            state_q <= S_IDLE;
          end else begin
            if (MRxErr) phy_err_q <= 1'b1;
            if (!phase_q) begin
              low_nib_q <= MRxD;
              phase_q   <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              if (count_q >= MAX_LEN_W) begin
                // This byte would exceed MAX_LEN: not counted, not emitted.
                long_err_q  <= 1'b1;
                state_q     <= S_DROP;
                from_data_q <= 1'b1;
              end else begin
                crc_q   <= crc_byte_w;
                count_q <= count_inc_w;
                word_q  <= word_ins_w;
                if (lane_w == 2'd3) begin
                  rx_valid_o   <= 1'b1;
                  rx_data_o    <= word_ins_w;
                  rx_be_o      <= 4'hF;
                  rx_sof_o     <= first_word_q;
                  first_word_q <= 1'b0;
                end
              end
            end
          end
        end

        S_DROP: begin
          if (!MRxDV) state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase

      if (end_frame_w) begin
        if (lane_w != 2'd0) begin
          rx_valid_o   <= 1'b1;
          rx_data_o    <= word_q;
          rx_be_o      <= tail_be_w;
          rx_sof_o     <= first_word_q;
          first_word_q <= 1'b0;
        end
        rx_done_o      <= 1'b1;
        rx_len_o       <= count_q;
        rx_crc_err_o   <= (crc_q != CRC_RESIDUE);
        rx_phy_err_o   <= phy_err_q;
        rx_short_err_o <= (count_q < MIN_LEN_W);
        rx_long_err_o  <= long_err_q;
        rx_align_err_o <= align_w;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_mii.sv
module tb_eth_rx_mii;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  logic        MRxClk = 1'b0;
  logic        prstn_i = 1'b0;
  logic [3:0]  MRxD = 4'h0;
  logic        MRxDV = 1'b0;
  logic        MRxErr = 1'b0;
  logic [31:0] rx_data_o;
  logic        rx_valid_o;
  logic [3:0]  rx_be_o;
  logic        rx_sof_o;
  logic        rx_done_o;
  logic [15:0] rx_len_o;
  logic        rx_crc_err_o;
  logic        rx_phy_err_o;
  logic        rx_short_err_o;
  logic        rx_long_err_o;
  logic        rx_align_err_o;

  eth_rx_mii #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .MRxClk        (MRxClk),
    .prstn_i       (prstn_i),
    .MRxD          (MRxD),
    .MRxDV         (MRxDV),
    .MRxErr        (MRxErr),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .rx_be_o       (rx_be_o),
    .rx_sof_o      (rx_sof_o),
    .rx_done_o     (rx_done_o),
    .rx_len_o      (rx_len_o),
    .rx_crc_err_o  (rx_crc_err_o),
    .rx_phy_err_o  (rx_phy_err_o),
    .rx_short_err_o(rx_short_err_o),
    .rx_long_err_o (rx_long_err_o),
    .rx_align_err_o(rx_align_err_o)
  );

  always #5 MRxClk = ~MRxClk;

  int cyc = 0;
  always @(posedge MRxClk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
    bit          sof;
    bit          at_done;
    int          at;
  } word_t;

  typedef struct {
    int len;
    bit crc;
    bit crc_known;
    bit phy;
    bit shrt;
    bit lng;
    bit align;
    int at;
  } stat_t;

  word_t      word_q[$];
  stat_t      stat_q[$];
  logic [7:0] tx_bytes[$];
  int         frame_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (frame %0d, cycle %0d): got %0h, expected %0h", name, frame_no, cyc, act, exp);
    end
  endtask

  // Reference CRC-32 (IEEE 802.3, reflected) over the first cnt frame bytes.
  function automatic logic [31:0] crc32_of(input int cnt);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < cnt; i++) begin
      c ^= {24'h0, tx_bytes[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bit fcs_ok();
    int n;
    n = tx_bytes.size();
    if (n < 4) return 1'b0;
    return {tx_bytes[n-1], tx_bytes[n-2], tx_bytes[n-3], tx_bytes[n-4]} == crc32_of(n - 4);
  endfunction

  // n total bytes; when n >= 4 the last four are a valid FCS, optionally
  // broken afterwards by flipping one payload bit.
  task automatic build_frame(input int n, input bit bad_fcs);
    logic [31:0] f;
    int p;
    tx_bytes.delete();
    p = (n >= 4) ? n - 4 : n;
    for (int i = 0; i < p; i++) tx_bytes.push_back(8'($urandom));
    if (n >= 4) begin
      f = crc32_of(p);
      for (int i = 0; i < 4; i++) tx_bytes.push_back(f[8*i +: 8]);
      if (bad_fcs && p > 0) tx_bytes[$urandom_range(0, p - 1)][$urandom_range(0, 7)] ^= 1'b1;
    end
  endtask

  task automatic drive(input logic [3:0] nib, input logic dv, input logic err);
    @(negedge MRxClk);
    MRxD   = nib;
    MRxDV  = dv;
    MRxErr = err;
  endtask

  task automatic send_frame(input int npre, input bit bad_pre, input bit dribble,
                            input int phy_at, input int rst_at, input int gap);
    int    n;
    int    k;
    int    base;
    bit    expect_out;
    word_t w;
    stat_t s;
    n          = tx_bytes.size();
    k          = (n > MAX_LEN) ? MAX_LEN : n;
    expect_out = !bad_pre;
    frame_no++;
    for (int i = 0; i < npre; i++) drive((bad_pre && i == npre / 2) ? 4'h7 : 4'h5, 1'b1, 1'b0);
    drive(4'hD, 1'b1, 1'b0);
    for (int j = 0; j < n; j++) begin
      drive(tx_bytes[j][3:0], 1'b1, j == phy_at);
      if (j == rst_at) begin
        prstn_i    = 1'b0;
        expect_out = 1'b0;
      end
      if (rst_at >= 0 && j == rst_at + 2) prstn_i = 1'b1;
      drive(tx_bytes[j][7:4], 1'b1, 1'b0);
      if (expect_out && j < k && (j % 4) == 3) begin
        w.data    = {tx_bytes[j], tx_bytes[j-1], tx_bytes[j-2], tx_bytes[j-3]};
        w.be      = 4'hF;
        w.sof     = (j == 3);
        w.at_done = 1'b0;
        w.at      = cyc + 1;
        word_q.push_back(w);
      end
    end
    if (dribble) drive(4'($urandom), 1'b1, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    if (expect_out) begin
      if ((k % 4) != 0) begin
        base   = k - (k % 4);
        w.data = 32'h0;
        for (int i = 0; i < k % 4; i++) w.data[8*i +: 8] = tx_bytes[base + i];
        w.be      = 4'((1 << (k % 4)) - 1);
        w.sof     = (k < 4);
        w.at_done = 1'b1;
        w.at      = cyc + 1;
        word_q.push_back(w);
      end
      s.len       = k;
      s.lng       = (n > MAX_LEN);
      s.crc_known = !s.lng;
      s.crc       = !fcs_ok();
      s.phy       = (phy_at >= 0 && phy_at < n);
      s.shrt      = (k < MIN_LEN);
      s.align     = dribble && !s.lng;
      s.at        = cyc + 1;
      stat_q.push_back(s);
    end
    repeat (gap) drive(4'h0, 1'b0, 1'b0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a word or status.
  always @(negedge MRxClk) begin
    word_t       e;
    stat_t       s;
    logic [31:0] m;
    if (rx_valid_o) begin
      if (word_q.size() == 0) begin
        chk("spurious_word", {31'h0, rx_valid_o}, 32'h0);
      end else begin
        e = word_q.pop_front();
        m = {{8{e.be[3]}}, {8{e.be[2]}}, {8{e.be[1]}}, {8{e.be[0]}}};
        chk("word_data", rx_data_o & m, e.data & m);
        chk("word_be", {28'h0, rx_be_o}, {28'h0, e.be});
        chk("word_sof", {31'h0, rx_sof_o}, {31'h0, e.sof});
        chk("word_with_done", {31'h0, rx_done_o}, {31'h0, e.at_done});
        chk("word_cycle", cyc, e.at);
        $display("word  frame %0d cycle %0d data %08h be %b sof %0b", frame_no, cyc, rx_data_o, rx_be_o, rx_sof_o);
      end
    end
    if (rx_done_o) begin
      chk("done_words_left", word_q.size(), 0);
      if (stat_q.size() == 0) begin
        chk("spurious_done", {31'h0, rx_done_o}, 32'h0);
      end else begin
        s = stat_q.pop_front();
        chk("done_len", {16'h0, rx_len_o}, s.len);
        if (s.crc_known) chk("done_crc_err", {31'h0, rx_crc_err_o}, {31'h0, s.crc});
        chk("done_phy_err", {31'h0, rx_phy_err_o}, {31'h0, s.phy});
        chk("done_short_err", {31'h0, rx_short_err_o}, {31'h0, s.shrt});
        chk("done_long_err", {31'h0, rx_long_err_o}, {31'h0, s.lng});
        chk("done_align_err", {31'h0, rx_align_err_o}, {31'h0, s.align});
        chk("done_cycle", cyc, s.at);
        $display("done  frame %0d cycle %0d len %0d crc %0b phy %0b short %0b long %0b align %0b",
                 frame_no, cyc, rx_len_o, rx_crc_err_o, rx_phy_err_o, rx_short_err_o,
                 rx_long_err_o, rx_align_err_o);
      end
    end
  end

  initial begin
    int n;
    int phy;
    prstn_i = 1'b0;
    repeat (3) @(negedge MRxClk);
    chk("reset_data", rx_data_o, 32'h0);
    chk("reset_valid", {31'h0, rx_valid_o}, 32'h0);
    chk("reset_be", {28'h0, rx_be_o}, 32'h0);
    chk("reset_sof", {31'h0, rx_sof_o}, 32'h0);
    chk("reset_done", {31'h0, rx_done_o}, 32'h0);
    chk("reset_len", {16'h0, rx_len_o}, 32'h0);
    chk("reset_crc", {31'h0, rx_crc_err_o}, 32'h0);
    chk("reset_phy", {31'h0, rx_phy_err_o}, 32'h0);
    chk("reset_short", {31'h0, rx_short_err_o}, 32'h0);
    chk("reset_long", {31'h0, rx_long_err_o}, 32'h0);
    chk("reset_align", {31'h0, rx_align_err_o}, 32'h0);
    prstn_i = 1'b1;
    repeat (2) drive(4'h0, 1'b0, 1'b0);

    build_frame(64, 1'b0);   send_frame(15, 1'b0, 1'b0, -1, -1, 3);  // good frame
    build_frame(64, 1'b1);   send_frame(15, 1'b0, 1'b0, -1, -1, 3);  // bad FCS
    build_frame(61, 1'b0);   send_frame(15, 1'b0, 1'b1, -1, -1, 3);  // short + dribble
    build_frame(64, 1'b0);   send_frame(15, 1'b1, 1'b0, -1, -1, 3);  // bad preamble
    build_frame(64, 1'b0);   send_frame(15, 1'b0, 1'b0, 20, -1, 3);  // PHY error
    build_frame(1600, 1'b0); send_frame(15, 1'b0, 1'b0, -1, -1, 3);  // oversize
    build_frame(1518, 1'b0); send_frame(7, 1'b0, 1'b0, -1, -1, 1);   // exactly MAX_LEN
    build_frame(63, 1'b0);   send_frame(3, 1'b0, 1'b0, -1, -1, 1);   // MIN_LEN - 1
    build_frame(0, 1'b0);    send_frame(2, 1'b0, 1'b0, -1, -1, 1);   // zero-byte frame
    build_frame(3, 1'b0);    send_frame(1, 1'b0, 1'b0, -1, -1, 1);   // single partial word
    build_frame(64, 1'b0);   send_frame(15, 1'b0, 1'b0, -1, 10, 3);  // reset mid-frame
    build_frame(64, 1'b0);   send_frame(15, 1'b0, 1'b0, -1, -1, 2);  // recovery

    for (int t = 0; t < 20; t++) begin
      n   = $urandom_range(0, 140);
      phy = (n > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
      build_frame(n, $urandom_range(0, 3) == 0);
      send_frame($urandom_range(1, 15), $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                 phy, -1, $urandom_range(1, 4));
    end

    repeat (10) drive(4'h0, 1'b0, 1'b0);
    chk("words_pending", word_q.size(), 0);
    chk("status_pending", stat_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
